// File: rtl/nf10_axis_pkt_gen.sv
// AXI4-Stream test-frame generator: HDR0 (MACs/EtherType), HDR1 (sequence
// number), then a patterned payload, repeated with a configurable idle gap.
module nf10_axis_pkt_gen #(
  parameter int         C_M_AXIS_DATA_WIDTH  = 256,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter int         C_PAYLOAD_WORDS      = 32,
  parameter int         C_GAP_CYCLES         = 128,
  parameter logic [7:0] C_SRC_PORT           = 8'h01
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [15:0]                       pkt_limit,
  input  logic [47:0]                       dst_mac,
  input  logic [47:0]                       src_mac,
  input  logic [15:0]                       ethertype,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,
  output logic [31:0]                       pkts_sent,
  output logic                              busy,
  output logic                              done
);

  localparam logic [15:0] PKT_LEN   = 16'((C_PAYLOAD_WORDS + 2) * 32);
  localparam logic [8:0]  LAST_BEAT = 9'(C_PAYLOAD_WORDS - 1);
  localparam int          GAP_W     = (C_GAP_CYCLES > 1) ? $clog2(C_GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(C_GAP_CYCLES - 1);
  localparam logic [C_M_AXIS_TUSER_WIDTH-1:0] TUSER_PKT =
    C_M_AXIS_TUSER_WIDTH'({8'h00, C_SRC_PORT, PKT_LEN});

  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_PAYLOAD, S_GAP, S_DONE} state_e;

  state_e                              state_q;
  logic                                tvalid_q, tlast_q, busy_q, done_q;
  logic [C_M_AXIS_DATA_WIDTH-1:0]      tdata_q;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]    tstrb_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]     tuser_q;
  logic [31:0]                         pkts_sent_q, seq_q;
  logic [15:0]                         pkt_cnt_q, limit_q;
  logic [8:0]                          beat_q;
  logic [GAP_W-1:0]                    gap_q;

  logic [8:0]  beat_d;
  logic [15:0] pkt_cnt_d;
  logic        xfer;

  assign beat_d    = beat_q + 9'd1;
  assign pkt_cnt_d = pkt_cnt_q + 16'd1;
  assign xfer      = tvalid_q & M_AXIS_TREADY;

  // Byte n sits at TDATA[8n+7:8n]; MACs and EtherType go out MSB byte first.
  function automatic logic [C_M_AXIS_DATA_WIDTH-1:0] hdr0_beat(
    input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
    logic [C_M_AXIS_DATA_WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < 6; i++) begin
      d[8*i +: 8]     = dst[8*(5-i) +: 8];
      d[8*(6+i) +: 8] = src[8*(5-i) +: 8];
    end
    d[103:96]  = et[15:8];
    d[111:104] = et[7:0];
    return d;
  endfunction

  function automatic logic [C_M_AXIS_DATA_WIDTH-1:0] payload_beat(input logic [7:0] b);
    return {{8{b}}, 64'hAAAAAAAABBBBBBBB, {8{b}}, 64'hBBBBBBBBCCCCCCCC};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tuser_q     <= '0;
      pkts_sent_q <= '0;
      seq_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pkt_cnt_q   <= '0;
      limit_q     <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (enable) begin
            state_q   <= S_HDR0;
            tvalid_q  <= 1'b1;
            tlast_q   <= 1'b0;
            tdata_q   <= hdr0_beat(dst_mac, src_mac, ethertype);
            tuser_q   <= TUSER_PKT;
            tstrb_q   <= '1;
            pkt_cnt_q <= '0;
            limit_q   <= pkt_limit;
            busy_q    <= 1'b1;
          end
        end
        S_HDR0: begin
          if (xfer) begin
            state_q <= S_HDR1;
            tdata_q <= C_M_AXIS_DATA_WIDTH'(seq_q);
          end
        end
        S_HDR1: begin
          if (xfer) begin
            state_q <= S_PAYLOAD;
            beat_q  <= '0;
            tdata_q <= payload_beat(8'd0);
            tlast_q <= (LAST_BEAT == 9'd0);
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            if (tlast_q) begin
              pkts_sent_q <= pkts_sent_q + 32'd1;
              seq_q       <= seq_q + 32'd1;
              pkt_cnt_q   <= pkt_cnt_d;
              tlast_q     <= 1'b0;
              if (limit_q != 16'd0 && pkt_cnt_d == limit_q) begin
                state_q  <= S_DONE;
                tvalid_q <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end else if (C_GAP_CYCLES == 0 && enable) begin
                // Back-to-back: TVALID stays high straight into the next header.
                state_q <= S_HDR0;
                tdata_q <= hdr0_beat(dst_mac, src_mac, ethertype);
              end else if (C_GAP_CYCLES == 0) begin
                state_q  <= S_IDLE;
                tvalid_q <= 1'b0;
                busy_q   <= 1'b0;
              end else begin
                state_q  <= S_GAP;
                tvalid_q <= 1'b0;
                gap_q    <= '0;
              end
            end else begin
              beat_q  <= beat_d;
              tdata_q <= payload_beat(beat_d[7:0]);
              tlast_q <= (beat_d == LAST_BEAT);
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (enable) begin
              state_q  <= S_HDR0;
              tvalid_q <= 1'b1;
              tdata_q  <= hdr0_beat(dst_mac, src_mac, ethertype);
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        S_DONE: begin
          if (!enable) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TSTRB  = tstrb_q;
  assign M_AXIS_TUSER  = tuser_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign pkts_sent     = pkts_sent_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Scoreboard bench for nf10_axis_pkt_gen: default instance (32 payload beats,
// 128-cycle gap) and a back-to-back instance (1 payload beat, no gap).
module tb_nf10_axis_pkt_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, enable_b, tready, tready_b;
  logic [15:0] pkt_limit, ethertype;
  logic [47:0] dst_mac, src_mac;

  logic [255:0] a_tdata, b_tdata;
  logic [31:0]  a_tstrb, b_tstrb, a_pkts, b_pkts;
  logic [127:0] a_tuser, b_tuser;
  logic         a_tvalid, a_tlast, a_busy, a_done;
  logic         b_tvalid, b_tlast, b_busy, b_done;

  nf10_axis_pkt_gen dut_a (
    .clk(clk), .reset(reset), .enable(enable), .pkt_limit(pkt_limit),
    .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
    .M_AXIS_TDATA(a_tdata), .M_AXIS_TSTRB(a_tstrb), .M_AXIS_TUSER(a_tuser),
    .M_AXIS_TVALID(a_tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TLAST(a_tlast),
    .pkts_sent(a_pkts), .busy(a_busy), .done(a_done));

  nf10_axis_pkt_gen #(.C_PAYLOAD_WORDS(1), .C_GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .pkt_limit(pkt_limit),
    .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
    .M_AXIS_TDATA(b_tdata), .M_AXIS_TSTRB(b_tstrb), .M_AXIS_TUSER(b_tuser),
    .M_AXIS_TVALID(b_tvalid), .M_AXIS_TREADY(tready_b), .M_AXIS_TLAST(b_tlast),
    .pkts_sent(b_pkts), .busy(b_busy), .done(b_done));

  // Hand-assembled header beats: byte 0 in the least-significant byte.
  localparam logic [255:0] H0_CAFE = {144'h0, 112'h0008_0000_EFBE_EFBE_FECA_FECA_FECA};
  localparam logic [255:0] H0_ALT  = {144'h0, 112'hDD86_BBAA_9988_7766_5544_3322_1100};
  localparam logic [127:0] A_USER  = 128'h0001_0440;
  localparam logic [127:0] B_USER  = 128'h0001_0060;

  typedef struct {
    logic [255:0] data;
    logic         last;
    logic [127:0] user;
    bit           hdr0;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pl(input logic [7:0] b);
    return {{8{b}}, 64'hAAAAAAAABBBBBBBB, {8{b}}, 64'hBBBBBBBBCCCCCCCC};
  endfunction

  task automatic push_pkt(input bit to_b, input logic [255:0] h0, input logic [31:0] seq,
                          input int nbeats, input int pw, input logic [127:0] user);
    beat_t e;
    for (int i = 0; i < nbeats; i++) begin
      e.user = user;
      e.hdr0 = (i == 0);
      e.last = (i == pw + 1);
      if (i == 0)      e.data = h0;
      else if (i == 1) e.data = {224'h0, seq};
      else             e.data = pl(8'(i - 2));
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  // Monitor A: pops one expected beat per transfer; optionally measures the idle gap.
  int cyc = 0, xfer_a = 0, last_cyc = 0;
  bit check_gap = 0, have_last = 0;
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (!reset && a_tvalid && tready) begin
      xfer_a++;
      if (qa.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat_a: got %h required no beat", a_tdata);
      end else begin
        e = qa.pop_front();
        check("tdata_a", a_tdata, e.data);
        check("tlast_a", 256'(a_tlast), 256'(e.last));
        check("tuser_a", 256'(a_tuser), 256'(e.user));
        check("tstrb_a", 256'(a_tstrb), 256'hFFFF_FFFF);
        if (check_gap && e.hdr0 && have_last)
          check("gap_a", 256'(cyc - last_cyc - 1), 256'd128);
        if (e.last) begin
          have_last = 1;
          last_cyc  = cyc;
        end
      end
    end
  end

  // Stall monitor A: a stalled beat must stay valid and unchanged.
  logic [255:0] st_data;
  logic         st_last;
  bit           st_pend = 0;
  always @(negedge clk) begin
    if (reset) st_pend = 0;
    else begin
      if (st_pend) begin
        check("stall_tvalid", 256'(a_tvalid), 256'd1);
        check("stall_tdata", a_tdata, st_data);
        check("stall_tlast", 256'(a_tlast), 256'(st_last));
      end
      st_pend = a_tvalid && !tready;
      st_data = a_tdata;
      st_last = a_tlast;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    beat_t e;
    if (!reset && b_tvalid && tready_b) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat_b: got %h required no beat", b_tdata);
      end else begin
        e = qb.pop_front();
        check("tdata_b", b_tdata, e.data);
        check("tlast_b", 256'(b_tlast), 256'(e.last));
        check("tuser_b", 256'(b_tuser), 256'(e.user));
      end
    end
  end

  task automatic wait_done(input int budget, input string name);
    bit hit;
    hit = 0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(posedge clk);
      #1;
      hit = a_done;
    end
    check(name, 256'(hit), 256'd1);
  endtask

  task automatic wait_xfer(input int target, input int budget, input string name);
    bit hit;
    hit = 0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(posedge clk);
      #1;
      hit = (xfer_a >= target);
    end
    check(name, 256'(hit), 256'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit hit;
    reset = 1; enable = 0; enable_b = 0; tready = 1; tready_b = 1;
    pkt_limit = 16'd3;
    dst_mac = 48'hCAFECAFECAFE; src_mac = 48'hBEEFBEEF0000; ethertype = 16'h0800;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_tvalid", 256'(a_tvalid), 256'd0);
    check("rst_tlast", 256'(a_tlast), 256'd0);
    check("rst_tdata", a_tdata, 256'd0);
    check("rst_tuser", 256'(a_tuser), 256'd0);
    check("rst_tstrb", 256'(a_tstrb), 256'd0);
    check("rst_pkts", 256'(a_pkts), 256'd0);
    check("rst_busy_done", 256'({a_busy, a_done}), 256'd0);
    check("rst_tvalid_b", 256'(b_tvalid), 256'd0);

    // Three packets with limit, full-rate ready, gap measured
    for (int s = 0; s < 3; s++) push_pkt(0, H0_CAFE, 32'(s), 34, 32, A_USER);
    check_gap = 1;
    @(posedge clk);
    #1 enable = 1;
    @(posedge clk);
    #1;
    check("latency_tvalid", 256'(a_tvalid), 256'd1);
    check("busy_running", 256'(a_busy), 256'd1);
    wait_done(1000, "t1_done_reached");
    check_gap = 0;
    check("t1_pkts", 256'(a_pkts), 256'd3);
    check("t1_done_state", 256'({a_tvalid, a_busy}), 256'd0);
    check("t1_queue_empty", 256'(qa.size()), 256'd0);
    enable = 0;
    @(posedge clk);
    #1;
    check("done_cleared", 256'(a_done), 256'd0);

    // One packet with random backpressure
    pkt_limit = 16'd1;
    push_pkt(0, H0_CAFE, 32'd3, 34, 32, A_USER);
    enable = 1;
    hit = 0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      @(posedge clk);
      #1 tready = 1'($urandom_range(0, 1));
      hit = a_done;
    end
    check("t2_done_reached", 256'(hit), 256'd1);
    tready = 1;
    enable = 0;
    check("t2_pkts", 256'(a_pkts), 256'd4);
    check("t2_queue_empty", 256'(qa.size()), 256'd0);
    @(posedge clk);
    #1;

    // Enable dropped during payload beat 10
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    check("t3_rst_pkts", 256'(a_pkts), 256'd0);
    dst_mac = 48'h001122334455; src_mac = 48'h66778899AABB; ethertype = 16'h86DD;
    pkt_limit = 16'd0;
    push_pkt(0, H0_ALT, 32'd0, 34, 32, A_USER);
    base = xfer_a;
    enable = 1;
    wait_xfer(base + 12, 200, "t3_reach_beat10");
    enable = 0;
    hit = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(posedge clk);
      #1 hit = !a_busy;
    end
    check("t3_returns_idle", 256'(hit), 256'd1);
    repeat (40) @(posedge clk);
    #1;
    check("t3_pkts", 256'(a_pkts), 256'd1);
    check("t3_idle_outputs", 256'({a_tvalid, a_busy, a_done}), 256'd0);
    check("t3_queue_empty", 256'(qa.size()), 256'd0);

    // Reset during payload beat 5, then a fresh packet
    push_pkt(0, H0_ALT, 32'd1, 7, 32, A_USER);
    base = xfer_a;
    enable = 1;
    wait_xfer(base + 7, 200, "t4_reach_beat5");
    reset = 1;
    @(posedge clk);
    #1;
    check("t4_abort_tvalid", 256'(a_tvalid), 256'd0);
    check("t4_abort_tlast", 256'(a_tlast), 256'd0);
    check("t4_abort_pkts", 256'(a_pkts), 256'd0);
    check("t4_abort_busy", 256'(a_busy), 256'd0);
    check("t4_abort_queue", 256'(qa.size()), 256'd0);
    pkt_limit = 16'd1;
    push_pkt(0, H0_ALT, 32'd0, 34, 32, A_USER);
    reset = 0;
    wait_done(300, "t4_done_reached");
    check("t4_pkts", 256'(a_pkts), 256'd1);
    check("t4_queue_empty", 256'(qa.size()), 256'd0);
    enable = 0;
    @(posedge clk);
    #1;

    // Back-to-back instance: 4 packets of 3 beats, then enable drops
    pkt_limit = 16'd0;
    for (int s = 0; s < 4; s++) push_pkt(1, H0_ALT, 32'(s), 3, 1, B_USER);
    enable_b = 1;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("b2b_tvalid", 256'(b_tvalid), 256'd1);
      if (i % 3 == 0) check("b2b_pkts", 256'(b_pkts), 256'(i / 3));
    end
    #1 enable_b = 0;
    @(negedge clk);
    check("b2b_stop_tvalid", 256'(b_tvalid), 256'd0);
    check("b2b_final_pkts", 256'(b_pkts), 256'd4);
    check("b2b_queue_empty", 256'(qb.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nf10_axis_pkt_gen.md
Name: nf10_axis_pkt_gen

Overview:
- Synthesizable AXI4-Stream Ethernet packet generator that sits directly upstream of nf10_axis_pbs_bridge and drives its 256-bit slave stream port.
- It generates fixed-format test frames (two header words plus a patterned payload) so the bridge and the 1G NIC port can be exercised on hardware without a host.
- Packet count, MACs and EtherType are runtime inputs; sizes and gaps are parameters.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, stream data width; only 256 supported.
C_M_AXIS_TUSER_WIDTH, 128, TUSER width; must be at least 32.
C_PAYLOAD_WORDS, 32, payload beats per packet; legal range 1..256.
C_GAP_CYCLES, 128, idle cycles between packets; 0 means back-to-back.
C_SRC_PORT, 8'h01, value driven in TUSER[23:16].

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; generator runs while high
pkt_limit  in  16  packets to send per enable; 0 = unlimited
dst_mac  in  48  destination MAC
src_mac  in  48  source MAC
ethertype  in  16  EtherType
M_AXIS_TDATA  out  256  stream data; byte n = TDATA[8n+7:8n]
M_AXIS_TSTRB  out  32  byte strobes
M_AXIS_TUSER  out  128  sideband
M_AXIS_TVALID  out  1  valid
M_AXIS_TREADY  in  1  ready
M_AXIS_TLAST  out  1  last beat
pkts_sent  out  32  completed packets, wraps at 2^32
busy  out  1  high in any state except IDLE and DONE
done  out  1  pkt_limit reached

Behaviour:
- All outputs are registered. Reset (synchronous, active-high, on clk) forces state IDLE and clears TVALID, TLAST, TDATA, TUSER, pkts_sent, busy, done, the per-enable packet count, the beat index, the gap counter and the sequence number to 0. TSTRB resets to 0.
- Reset asserted mid-packet aborts the packet immediately. TVALID is 0 in the cycle after the reset edge, and no TLAST is issued for the aborted packet.
- FSM states: IDLE, HDR0, HDR1, PAYLOAD, GAP, DONE.
- IDLE: if enable=1, go to HDR0; TVALID rises on the next cycle (one cycle latency from enable sampled high). The per-enable packet count clears on entry to HDR0 from IDLE.
- HDR0 beat: bytes 0-5 = dst_mac (MSB byte first), bytes 6-11 = src_mac, bytes 12-13 = ethertype (MSB first), bytes 14-31 = 0.
- HDR1 beat: bytes 0-3 = sequence number (little-endian, 32-bit), bytes 4-31 = 0.
- PAYLOAD beat k (k = 0..C_PAYLOAD_WORDS-1, with b = k[7:0]) = {{8{b}},64'hAAAAAAAABBBBBBBB,{8{b}},64'hBBBBBBBBCCCCCCCC}.
- TLAST=1 only on beat k = C_PAYLOAD_WORDS-1.
- Handshake: a beat transfers when TVALID & TREADY. While TVALID=1 and TREADY=0, TDATA, TUSER, TSTRB and TLAST hold stable. TVALID never drops without a transfer (except on reset). State advances only on transfer.
- TSTRB = 32'hFFFF_FFFF on every valid beat.
- TUSER is constant for all beats of a packet:
  - [15:0] = (C_PAYLOAD_WORDS+2)*32 (byte length)
  - [23:16] = C_SRC_PORT
  - [31:24] = 0
  - upper bits = 0
- On the last-beat transfer:
  - pkts_sent increments and the sequence number increments.
  - The per-enable count increments.
  - If pkt_limit != 0 and the new count == pkt_limit, go to DONE.
  - Else if C_GAP_CYCLES = 0 and enable = 1, go to HDR0 (back-to-back: TVALID stays high, HDR0 presented the next cycle).
  - Else if C_GAP_CYCLES = 0 and enable = 0, go to IDLE.
  - Else go to GAP.
- GAP: TVALID=0 for exactly C_GAP_CYCLES cycles, then HDR0 if enable=1, else IDLE.
- enable deasserted mid-packet: the current packet completes normally (no truncation), then the FSM goes to IDLE via GAP (or directly to IDLE when C_GAP_CYCLES = 0).
- DONE: TVALID=0, done=1. Stays until enable=0, then goes to IDLE with done cleared.
- pkt_limit and the MACs/EtherType are sampled on entry to HDR0 and held for the whole packet; pkt_limit is also held for the whole enable period.
- pkts_sent and the sequence number persist across enable cycles and clear only on reset.

Test Plan:
- Defaults, TREADY=1, enable=1, pkt_limit=3 -> three 34-beat packets, each TLAST on beat 34 only, exactly 128 TVALID-low cycles between packets. Afterwards: done=1, pkts_sent=3, sequence numbers 0,1,2 in HDR1 bytes 0-3, TUSER[15:0]=16'd1088.
- TREADY toggled pseudo-randomly -> payload beats 0..31 received in order with no drops or duplicates. While TVALID=1 and TREADY=0, TDATA/TLAST remain stable (checked every stalled cycle).
- dst_mac=48'hCAFECAFECAFE, src_mac=48'hBEEFBEEF0000, ethertype=16'h0800 -> HDR0 bytes 0-13 equal CA FE CA FE CA FE BE EF BE EF 00 00 08 00, remaining bytes zero.
- enable dropped during payload beat 10 -> packet completes through TLAST, pkts_sent=1, no new HDR0 appears, FSM returns to IDLE after the gap.
- reset pulsed during payload beat 5 -> TVALID=0 next cycle and all counters 0. Re-enable -> fresh HDR0 with sequence number 0.
- C_GAP_CYCLES=0, C_PAYLOAD_WORDS=1, pkt_limit=0, TREADY=1 -> continuous TVALID, repeating 3-beat packets (HDR0, HDR1, payload beat with TLAST), pkts_sent increments every 3 cycles.
